// File: rtl/alu_decode_stage_pkg.sv
// Shared configuration for the ALU decode stage: op codes, opcodes, operand width, decode record.
package pkg_config;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b011001;
  localparam logic [5:0] ALU_SUB  = 6'b011011;
  localparam logic [5:0] ALU_AND  = 6'b011101;
  localparam logic [5:0] ALU_OR   = 6'b011111;
  localparam logic [5:0] ALU_XOR  = 6'b100001;
  localparam logic [5:0] ALU_SLT  = 6'b100011;
  localparam logic [5:0] ALU_SLTU = 6'b100101;
  localparam logic [5:0] ALU_SLL  = 6'b100111;
  localparam logic [5:0] ALU_SRL  = 6'b101001;
  localparam logic [5:0] ALU_SRA  = 6'b101011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [5:0]            alu_op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            rd;
    logic                  rd_we;
    logic                  illegal;
  } decode_t;

  // alt selects SUB/SRA; only meaningful for funct3 000 and 101
  function automatic logic [5:0] alu_op_for(input logic [2:0] funct3, input logic alt);
    logic [5:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Handshake and payload bundle of the ALU decode stage; slave is the stage, master its environment.
interface alu_decode_stage_if;
  import pkg_config::*;

  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           instr_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [5:0]            alu_op_o;
  logic [DATA_WIDTH-1:0] a_o;
  logic [DATA_WIDTH-1:0] b_o;
  logic [4:0]            rd_o;
  logic                  rd_we_o;
  logic                  illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_op_o, a_o, b_o, rd_o, rd_we_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_op_o, a_o, b_o, rd_o, rd_we_o, illegal_o
  );

endinterface

// File: rtl/alu_decode_stage_decoder.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing ALU op and operands.
// Malformed funct7 checking is enabled by ALU_DECODE_ILLEGAL_EN.
module alu_op_decoder
  import pkg_config::*;
(
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output decode_t               dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_alu;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

`ifdef ALU_DECODE_ILLEGAL_EN
  logic [6:0] funct7;
  assign funct7 = instr[31:25];
`endif

  always_comb begin
    dec    = '0;
    is_alu = 1'b0;
    legal  = 1'b1;
    dec.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        is_alu     = 1'b1;
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        dec.alu_op = alu_op_for(funct3, instr[30]);
`ifdef ALU_DECODE_ILLEGAL_EN
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`endif
      end
      OPC_OP_IMM: begin
        is_alu     = 1'b1;
        dec.a      = rs1_data;
        dec.b      = DATA_WIDTH'($signed(instr[31:20]));
        // no SUBI: bit 30 only picks SRAI, elsewhere it is immediate data
        dec.alu_op = alu_op_for(funct3, instr[30] && (funct3 == 3'b101));
`ifdef ALU_DECODE_ILLEGAL_EN
        if (funct3 == 3'b001)
          legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
`endif
      end
      OPC_LUI: begin
        is_alu     = 1'b1;
        dec.alu_op = ALU_ADD;
        dec.b      = DATA_WIDTH'({instr[31:12], 12'h000});
      end
      OPC_AUIPC: begin
        is_alu     = 1'b1;
        dec.alu_op = ALU_ADD;
        dec.a      = pc;
        dec.b      = DATA_WIDTH'({instr[31:12], 12'h000});
      end
      default: ;
    endcase
    if (!legal) begin
      dec.alu_op  = ALU_NOP;
      dec.a       = '0;
      dec.b       = '0;
      dec.illegal = 1'b1;
      is_alu      = 1'b0;
    end
    dec.rd_we = is_alu && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: one-entry valid/ready register in front of execute.
module alu_decode_stage
  import pkg_config::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  alu_decode_stage_if.slave  bus
);

  decode_t dec;
  decode_t entry_d, entry_q;
  logic    valid_d, valid_q;
  logic    in_ready;
  logic    accept;

  alu_op_decoder u_decoder (
    .instr    (bus.instr_i),
    .pc       (bus.pc_i),
    .rs1_data (bus.rs1_data_i),
    .rs2_data (bus.rs2_data_i),
    .dec      (dec)
  );

  assign in_ready = !valid_q || bus.out_ready_i;
  assign accept   = bus.in_valid_i && in_ready;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      entry_d = dec;
      valid_d = 1'b1;
    end else if (bus.out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = valid_q;
  assign bus.alu_op_o    = entry_q.alu_op;
  assign bus.a_o         = entry_q.a;
  assign bus.b_o         = entry_q.b;
  assign bus.rd_o        = entry_q.rd;
  assign bus.rd_we_o     = entry_q.rd_we;
  assign bus.illegal_o   = entry_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: random traffic against a queue-based model, then directed cases.
// Expectations follow ALU_DECODE_ILLEGAL_EN when it is defined for the build.
module tb_alu_decode_stage;

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  localparam logic [5:0] E_NOP = 6'b000000, E_ADD = 6'b011001, E_SUB = 6'b011011,
                         E_AND = 6'b011101, E_OR  = 6'b011111, E_XOR = 6'b100001,
                         E_SLT = 6'b100011, E_SLTU = 6'b100101, E_SLL = 6'b100111,
                         E_SRL = 6'b101001, E_SRA = 6'b101011;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [4:0] consumed_rd[$];

  alu_decode_stage_if bus();

  alu_decode_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t       e;
    logic [5:0] base [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit         alu, bad;
    base = '{E_ADD, E_SLL, E_SLT, E_SLTU, E_XOR, E_SRL, E_OR, E_AND};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    alu = 0;
    bad = 0;
    e = '{op: E_NOP, a: 32'd0, b: 32'd0, rd: ins[11:7], we: 1'b0, ill: 1'b0};
    if (opc == 7'b0110011) begin
      alu = 1; e.a = r1; e.b = r2; e.op = base[f3];
      if (f7[5] && f3 == 3'd0) e.op = E_SUB;
      if (f7[5] && f3 == 3'd5) e.op = E_SRA;
      if (ILL_EN) bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    end else if (opc == 7'b0010011) begin
      alu = 1; e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.op = base[f3];
      if (f7[5] && f3 == 3'd5) e.op = E_SRA;
      if (ILL_EN) bad = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    end else if (opc == 7'b0110111) begin
      alu = 1; e.op = E_ADD; e.b = {ins[31:12], 12'h000};
    end else if (opc == 7'b0010111) begin
      alu = 1; e.op = E_ADD; e.a = pc; e.b = {ins[31:12], 12'h000};
    end
    if (bad) begin
      alu = 0; e.op = E_NOP; e.a = 32'd0; e.b = 32'd0; e.ill = 1'b1;
    end
    e.we = alu && (e.rd != 5'd0);
    return e;
  endfunction

  // One clock: check ready, advance the model across the edge, check the registered outputs.
  task automatic step();
    logic rdy_exp;
    bit   acc, pop;
    exp_t nx;
    #1;
    rdy_exp = (q.size() == 0) || bus.out_ready_i;
    if (!rst) cmp("in_ready", {31'd0, bus.in_ready_o}, {31'd0, rdy_exp});
    acc = bus.in_valid_i && rdy_exp;
    pop = (q.size() != 0) && bus.out_ready_i;
    nx  = model(bus.instr_i, bus.pc_i, bus.rs1_data_i, bus.rs2_data_i);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      cmp("rst_op", {26'd0, bus.alu_op_o}, 32'd0);
      cmp("rst_a", bus.a_o, 32'd0);
      cmp("rst_b", bus.b_o, 32'd0);
      cmp("rst_rd", {27'd0, bus.rd_o}, 32'd0);
      cmp("rst_we", {31'd0, bus.rd_we_o}, 32'd0);
      cmp("rst_ill", {31'd0, bus.illegal_o}, 32'd0);
    end else if (bus.flush_i) begin
      q.delete();
    end else begin
      if (pop) begin
        consumed_rd.push_back(q[0].rd);
        void'(q.pop_front());
      end
      if (acc) q.push_back(nx);
    end
    cmp("out_valid", {31'd0, bus.out_valid_o}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      cmp("op", {26'd0, bus.alu_op_o}, {26'd0, q[0].op});
      cmp("a", bus.a_o, q[0].a);
      cmp("b", bus.b_o, q[0].b);
      cmp("rd", {27'd0, bus.rd_o}, {27'd0, q[0].rd});
      cmp("rd_we", {31'd0, bus.rd_we_o}, {31'd0, q[0].we});
      cmp("illegal", {31'd0, bus.illegal_o}, {31'd0, q[0].ill});
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  others [6];
    logic [6:0]  f7;
    others = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
    ins = $urandom;
    case ($urandom_range(0, 3))
      0:       f7 = 7'h20;
      1:       f7 = 7'($urandom);
      default: f7 = 7'h00;
    endcase
    case ($urandom_range(0, 5))
      0: begin ins[6:0] = 7'b0110011; ins[31:25] = f7; end
      1: begin ins[6:0] = 7'b0010011; ins[31:25] = f7; end
      2: ins[6:0] = 7'b0110111;
      3: ins[6:0] = 7'b0010111;
      4: ins[6:0] = others[$urandom_range(0, 5)];
      default: ;
    endcase
    return ins;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid_i  = 1'b1;
    bus.instr_i     = ins;
    bus.rs1_data_i  = r1;
    bus.rs2_data_i  = r2;
    bus.pc_i        = 32'h0000_1000;
    bus.out_ready_i = 1'b1;
    bus.flush_i     = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] bp_list [3];
    int          idx;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.instr_i = '0; bus.pc_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
    step();
    step();
    rst = 1'b0;

    for (int unsigned i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      bus.in_valid_i  = ($urandom_range(0, 3) != 0);
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      bus.instr_i     = rand_instr();
      bus.pc_i        = $urandom;
      bus.rs1_data_i  = $urandom;
      bus.rs2_data_i  = $urandom;
      step();
    end
    rst = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    step();

    drive(32'hFFF00093, 32'd0, 32'd0);
    cmp("addi_op", {26'd0, bus.alu_op_o}, {26'd0, 6'b011001});
    cmp("addi_a", bus.a_o, 32'd0);
    cmp("addi_b", bus.b_o, 32'hFFFF_FFFF);
    cmp("addi_rd", {27'd0, bus.rd_o}, 32'd1);
    cmp("addi_we", {31'd0, bus.rd_we_o}, 32'd1);

    drive(32'h40208133, 32'd10, 32'd3);
    cmp("sub_op", {26'd0, bus.alu_op_o}, {26'd0, 6'b011011});
    cmp("sub_a", bus.a_o, 32'd10);
    cmp("sub_b", bus.b_o, 32'd3);
    cmp("sub_rd", {27'd0, bus.rd_o}, 32'd2);

    drive(32'h4040D193, 32'd7, 32'd0);
    cmp("srai_op", {26'd0, bus.alu_op_o}, {26'd0, 6'b101011});
    cmp("srai_b", bus.b_o, 32'h0000_0404);

    drive(32'h02208133, 32'd5, 32'd6);
    cmp("f7_01_op", {26'd0, bus.alu_op_o}, ILL_EN ? 32'd0 : {26'd0, 6'b011001});
    cmp("f7_01_we", {31'd0, bus.rd_we_o}, {31'd0, !ILL_EN});
    cmp("f7_01_ill", {31'd0, bus.illegal_o}, {31'd0, ILL_EN});

    drive(32'h00500013, 32'd0, 32'd0);
    cmp("addi_x0_we", {31'd0, bus.rd_we_o}, 32'd0);

    drive(32'h00002083, 32'd9, 32'd9);
    cmp("load_op", {26'd0, bus.alu_op_o}, 32'd0);
    cmp("load_we", {31'd0, bus.rd_we_o}, 32'd0);

    // backpressure: three back-to-back ADDIs to x5/x6/x7, consumer stalls two cycles
    bus.in_valid_i = 1'b0; step();
    bp_list = '{32'h00100293, 32'h00200313, 32'h00300393};
    consumed_rd.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      bit will_acc;
      bus.out_ready_i = (c >= 3);
      bus.in_valid_i  = (idx < 3);
      bus.instr_i     = bp_list[idx < 3 ? idx : 2];
      bus.rs1_data_i  = 32'd0;
      will_acc = bus.in_valid_i && ((q.size() == 0) || bus.out_ready_i);
      step();
      if (will_acc) idx++;
      if (c == 1 || c == 2) begin
        cmp("bp_ready_low", {31'd0, bus.in_ready_o}, 32'd0);
        cmp("bp_frozen_b", bus.b_o, 32'd1);
      end
    end
    cmp("bp_count", consumed_rd.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      cmp("bp_order", {27'd0, (k < consumed_rd.size()) ? consumed_rd[k] : 5'd0}, 32'(5 + k));

    // flush while full and stalled, with a valid input in the same cycle
    bus.out_ready_i = 1'b0;
    drive(32'h00A00413, 32'd0, 32'd0);
    bus.out_ready_i = 1'b0; bus.in_valid_i = 1'b1; bus.flush_i = 1'b1;
    bus.instr_i = 32'h00B00493;
    step();
    cmp("flush_valid", {31'd0, bus.out_valid_o}, 32'd0);
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    step();
    cmp("flush_dropped", {31'd0, bus.out_valid_o}, 32'd0);

    // reset mid-stream
    drive(32'h00C00513, 32'd0, 32'd0);
    rst = 1'b1; bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b0;
    step();
    cmp("rst_mid_valid", {31'd0, bus.out_valid_o}, 32'd0);
    rst = 1'b0; bus.in_valid_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that produces the ALU's operation code and operands. It takes a fetched RV32I instruction plus register-file read data, decodes OP, OP-IMM, LUI and AUIPC into an ALU operation, and presents `alu_op`, `a`, `b` and destination info through a one-entry valid/ready pipeline register. It sits between fetch/register-file read and the execute stage that drives the ALU.

## Interface
- `DATA_WIDTH`, 32: operand width, taken from `pkg_config`.
- `clk_i` input 1: clock; the only clock.
- `rst_i` input 1: synchronous, active-high reset.
- `flush_i` input 1: discards the held entry and any same-cycle input.
- `in_valid_i` input 1: instruction and data are valid.
- `in_ready_o` output 1: the stage accepts input this cycle.
- `instr_i` input 32: instruction word.
- `pc_i` input DATA_WIDTH: PC of `instr_i`.
- `rs1_data_i` input DATA_WIDTH: register-file value for `instr_i[19:15]`.
- `rs2_data_i` input DATA_WIDTH: register-file value for `instr_i[24:20]`.
- `out_valid_o` output 1: the registered entry is valid.
- `out_ready_i` input 1: execute consumes the entry.
- `alu_op_o` output 6: ALU op code.
- `a_o` output DATA_WIDTH: ALU operand A.
- `b_o` output DATA_WIDTH: ALU operand B.
- `rd_o` output 5: destination register.
- `rd_we_o` output 1: write-back enable.
- `illegal_o` output 1: malformed OP/OP-IMM encoding.

## Operation
- Op codes: NOP 000000, ADD 011001, SUB 011011, AND 011101, OR 011111, XOR 100001, SLT 100011, SLTU 100101, SLL 100111, SRL 101001, SRA 101011.
- **OP (0110011)**: A = rs1_data, B = rs2_data. funct3 selects the op: 000 ADD/SUB (SUB when funct7 = 0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7 = 0100000), 110 OR, 111 AND.
  - Only funct7 = 0000000 is legal, except 0100000, which is legal only with funct3 000 or 101.
- **OP-IMM (0010011)**: A = rs1_data, B = the sign-extended I-immediate `instr[31:20]`. There is no SUBI.
  - SLLI requires funct7 = 0000000.
  - SRLI/SRAI requires funct7 = 0000000 or 0100000 respectively.
  - B still carries the full immediate; the ALU uses only B[4:0].
- **LUI (0110111)**: op = ADD, A = 0, B = `{instr[31:12], 12'b0}`.
- **AUIPC (0010111)**: op = ADD, A = pc_i, B = `{instr[31:12], 12'b0}`.
- **Any other opcode**: op = NOP, A = B = 0, rd_we = 0, illegal = 0. Such instructions belong to other units.
- `rd_o = instr[11:7]`. `rd_we_o = 1` only for a decoded ALU operation with rd ≠ 0.
- Illegal entry: op = NOP, rd_we = 0, illegal_o = 1.

## Timing
- Latency is 1 cycle, from an accepted input to `out_valid_o`.
- `in_ready_o = !out_valid_o || out_ready_i`, combinational. Accept when `in_valid_i && in_ready_o`.
- Each cycle, in priority order:
  1. rst: out_valid 0; alu_op NOP; a, b, rd 0; rd_we 0; illegal 0.
  2. flush: out_valid 0 next cycle; input that cycle is dropped, even if handshaken.
  3. accept: load the decoded entry and set out_valid 1.
  4. `out_ready_i` with no accept: clear out_valid.
  5. Otherwise: hold.
- Full throughput: with `out_ready_i` held at 1, one instruction per cycle with no bubbles.
- Outputs stay stable while `out_valid_o && !out_ready_i`.
- `out_valid_o`, `alu_op_o`, `a_o`, `b_o`, `rd_o`, `rd_we_o` and `illegal_o` all come from flops.
- Reset mid-stream discards the held entry; there is no partial output.

## Configuration
- `ALU_DECODE_ILLEGAL_EN`:
  - **Defined**: malformed OP/OP-IMM encodings are flagged with illegal_o = 1, op NOP, rd_we 0.
  - **Undefined**: `illegal_o` is tied 0 and funct7 is ignored except bit 5 for SUB/SRA/SRAI. For example, funct7 0000001 decodes as the base op.

## Structure
- `pkg_config` holds:
  - the ALU op-code constants, shared with the ALU;
  - opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`;
  - `DATA_WIDTH`;
  - a `decode_t` struct `{alu_op, a, b, rd, rd_we, illegal}`.
- Sub-module `alu_op_decoder`: purely combinational; `instr`, `pc`, rs data in, `decode_t` out. The stage itself holds only the register and the handshake.

## Test plan
- **ADDI x1,x0,-1**: 0xFFF00093, rs1_data = 0 → next cycle op 011001, A = 0, B = 0xFFFFFFFF, rd = 1, rd_we = 1.
- **SUB x2,x1,x2**: 0x40208133, rs1 = 10, rs2 = 3 → op 011011, A = 10, B = 3, rd = 2. **SRAI x3,x1,4**: 0x4040D193 → op 101011, B = 0x404.
- **Backpressure**: 3 back-to-back instructions with out_ready_i low for 2 cycles → in_ready_o low and outputs frozen; all 3 emerge in order, none lost or duplicated.
- **Flush while full and out_ready_i = 0**, with a same-cycle valid input → out_valid_o = 0 next cycle; the input never appears.
- **0x02208133 (funct7 0000001)**:
  - With the macro: illegal_o = 1, op 000000, rd_we = 0.
  - Without it: op ADD, rd_we = 1, illegal_o = 0.
- **ADDI x0** (0x00500013) → rd_we = 0. **Load opcode** 0x00002083 → op NOP. **Reset** asserted mid-stream → every output at its reset value the next cycle.
